// File: rtl/envelope_follower_pkg.sv
// Shared types and helpers for the envelope follower: sample width, phase encoding
// and the minimum-one step used by both the attack and release paths.
package envelope_follower_pkg;

    localparam int unsigned SampleW = 16;
    localparam int unsigned MathW   = SampleW + 1;
    localparam int unsigned CountW  = 16;

    typedef enum logic [1:0] {
        PhIdle = 2'd0,
        PhRise = 2'd1,
        PhHold = 2'd2,
        PhFall = 2'd3
    } phase_e;

    // Shifted difference, never allowed to stall at zero.
    function automatic logic [MathW-1:0] min1_step(input logic [MathW-1:0] diff,
                                                   input int unsigned      shift);
        logic [MathW-1:0] s;
        s = diff >> shift;
        return (s == '0) ? MathW'(1) : s;
    endfunction

endpackage

// File: rtl/envelope_follower_abs_sat.sv
// Combinational saturating absolute value of a two's-complement sample;
// the most negative code maps to the most positive one.
module envelope_follower_abs_sat
    import envelope_follower_pkg::*;
(
    input  logic [SampleW-1:0] sample_i,
    output logic [SampleW-1:0] abs_o
);

    localparam logic [SampleW-1:0] MinNeg = {1'b1, {(SampleW-1){1'b0}}};
    localparam logic [SampleW-1:0] MaxPos = {1'b0, {(SampleW-1){1'b1}}};

    always_comb begin
        if (!sample_i[SampleW-1]) begin
            abs_o = sample_i;
        end else if (sample_i == MinNeg) begin
            abs_o = MaxPos;
        end else begin
            abs_o = (~sample_i) + SampleW'(1);
        end
    end

endmodule

// File: rtl/envelope_follower.sv
// Peak/hold/release envelope tracker on |sample| with a hysteretic gate.
// Two stages: rectify on the input strobe, then update envelope, phase, hold count and gate.
module envelope_follower
    import envelope_follower_pkg::*;
#(
    parameter int unsigned ATTACK_SHIFT  = 2,
    parameter int unsigned RELEASE_SHIFT = 4,
    parameter int unsigned HOLD_SAMPLES  = 480,
    parameter int unsigned ON_THRESH     = 4096,
    parameter int unsigned OFF_THRESH    = 2048
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SampleW-1:0] sample_in,
    input  logic               in_ready,
    output logic [SampleW-1:0] env_out,
    output logic               gate_out,
    output logic [1:0]         phase_out,
    output logic               out_ready
);

    localparam logic [CountW-1:0] HoldLast = CountW'(HOLD_SAMPLES - 1);
    localparam logic [MathW-1:0]  OnLevel  = MathW'(ON_THRESH);
    localparam logic [MathW-1:0]  OffLevel = MathW'(OFF_THRESH);
    localparam logic [SampleW-1:0] EnvMax  = {1'b0, {(SampleW-1){1'b1}}};

    logic [SampleW-1:0] abs_w;
    logic [SampleW-1:0] abs_q;
    logic               vld_q;

    phase_e             state_q, state_d;
    logic [MathW-1:0]   env_q, env_d;
    logic [CountW-1:0]  cnt_q, cnt_d;
    logic               gate_q, gate_d;
    logic               rdy_q;
    logic [MathW-1:0]   abs_x;

    envelope_follower_abs_sat u_abs_sat (
        .sample_i (sample_in),
        .abs_o    (abs_w)
    );

    // Stage 0: rectify the strobed sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            abs_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_ready;
            if (in_ready) begin
                abs_q <= abs_w;
            end
        end
    end

    // Stage 1: state register, advanced only on a valid rectified sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PhIdle;
            env_q   <= '0;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= vld_q;
            if (vld_q) begin
                state_q <= state_d;
                env_q   <= env_d;
                cnt_q   <= cnt_d;
                gate_q  <= gate_d;
            end
        end
    end

    // Next-state and step arithmetic, all compared against the pre-update envelope.
    always_comb begin
        abs_x   = {1'b0, abs_q};
        state_d = state_q;
        env_d   = env_q;
        cnt_d   = cnt_q;
        gate_d  = gate_q;

        if (abs_x > env_q) begin
            state_d = PhRise;
            env_d   = env_q + min1_step(abs_x - env_q, ATTACK_SHIFT);
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                PhRise: begin
                    state_d = PhHold;
                    cnt_d   = '0;
                end
                PhHold: begin
                    cnt_d = cnt_q + CountW'(1);
                    if (cnt_q == HoldLast) begin
                        state_d = PhFall;
                    end
                end
                PhFall: begin
                    if (abs_x < env_q) begin
                        env_d = env_q - min1_step(env_q - abs_x, RELEASE_SHIFT);
                        if (env_d == '0) begin
                            state_d = PhIdle;
                        end
                    end
                end
                PhIdle: begin
                    state_d = PhIdle;
                end
                default: begin
                    state_d = PhIdle;
                end
            endcase
        end

        // Gate hysteresis sees the envelope this sample produces.
        if (env_d >= OnLevel) begin
            gate_d = 1'b1;
        end else if (env_d < OffLevel) begin
            gate_d = 1'b0;
        end
    end

    always_comb begin
        env_out   = env_q[MathW-1] ? EnvMax : env_q[SampleW-1:0];
        gate_out  = gate_q;
        phase_out = state_q;
        out_ready = rdy_q;
    end

endmodule

// File: tb/tb_envelope_follower.sv
// Directed bench for envelope_follower: reset behaviour, attack, hold length,
// release, gate hysteresis, back-to-back strobes and hold retrigger.
module tb_envelope_follower;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        in_ready;
    logic [15:0] env_out;
    logic        gate_out;
    logic [1:0]  phase_out;
    logic        out_ready;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    envelope_follower dut (
        .clk       (clk),
        .reset     (reset),
        .sample_in (sample_in),
        .in_ready  (in_ready),
        .env_out   (env_out),
        .gate_out  (gate_out),
        .phase_out (phase_out),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One strobe; returns sampled 1 ns after the edge where out_ready should be high.
    task automatic send(input logic [15:0] s);
        @(negedge clk);
        sample_in = s;
        in_ready  = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen;
        int unsigned holds;
        int unsigned ramp_env  [6] = '{1250, 2187, 2890, 3417, 3812, 4109};
        logic        ramp_gate [6] = '{0, 0, 0, 0, 0, 1};
        int unsigned fall_env  [11] = '{3853, 3613, 3388, 3177, 2979, 2793, 2619, 2456,
                                        2303, 2160, 2025};
        logic        fall_gate [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int unsigned tail_env  [5] = '{4, 3, 2, 1, 0};
        int unsigned tail_ph   [5] = '{3, 3, 3, 3, 0};

        reset     = 1'b1;
        in_ready  = 1'b0;
        sample_in = '0;

        // 1: strobes under reset are ignored.
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_ready  = 1'b1;
            sample_in = 16'h4000;
            @(posedge clk);
            #1;
            seen = seen | out_ready;
        end
        @(negedge clk);
        in_ready = 1'b0;
        reset    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            seen = seen | out_ready;
        end
        check("rst_no_ready", seen, 0);
        check("rst_env", env_out, 0);
        check("rst_gate", gate_out, 0);
        check("rst_phase", phase_out, 0);

        // Reset between E0 and E1 drops the in-flight sample.
        @(negedge clk);
        in_ready  = 1'b1;
        sample_in = 16'h4000;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rdy_e1", out_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_rdy_e2", out_ready, 0);
        check("midrst_env", env_out, 0);

        // 2: constant 16000 with exact latency.
        @(negedge clk);
        sample_in = 16'd16000;
        in_ready  = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        check("lat_e0_rdy", out_ready, 0);
        @(posedge clk);
        #1;
        check("lat_e1_rdy", out_ready, 1);
        check("rise1_env", env_out, 4000);
        check("rise1_phase", phase_out, 1);
        check("rise1_gate", gate_out, 0);
        @(posedge clk);
        #1;
        check("lat_e2_rdy", out_ready, 0);
        check("env_holds", env_out, 4000);
        send(16'd16000);
        check("rise2_env", env_out, 7000);
        check("rise2_gate", gate_out, 1);
        send(16'd16000);
        check("rise3_env", env_out, 9250);
        check("rise3_phase", phase_out, 1);

        // 3: most negative sample saturates.
        do_reset();
        send(16'h8000);
        check("sat_env", env_out, 8191);
        check("sat_phase", phase_out, 1);
        check("sat_gate", gate_out, 1);

        // 4: settle at 16000, hold, then release.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            send(16'd16000);
            if (env_out == 16'd16000) break;
        end
        check("settle_env", env_out, 16000);
        check("settle_phase", phase_out, 1);
        send(16'd16000);
        check("hold_entry_phase", phase_out, 2);
        check("hold_entry_env", env_out, 16000);
        holds = 1;
        for (int i = 0; i < 1000; i++) begin
            send(16'd0);
            if (phase_out != 2'd2) break;
            holds++;
        end
        check("hold_len", holds, 480);
        check("hold_to_fall_phase", phase_out, 3);
        check("hold_to_fall_env", env_out, 16000);
        send(16'd0);
        check("fall1_env", env_out, 15000);
        check("fall1_phase", phase_out, 3);
        send(16'd0);
        check("fall2_env", env_out, 14063);

        // 5: gate hysteresis on a ramp up and down, then release to idle.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(16'd5000);
            check($sformatf("ramp%0d_env", i), env_out, ramp_env[i]);
            check($sformatf("ramp%0d_gate", i), gate_out, ramp_gate[i]);
        end
        repeat (480) send(16'd0);
        check("g_hold_phase", phase_out, 2);
        send(16'd0);
        check("g_fall_phase", phase_out, 3);
        check("g_fall_env", env_out, 4109);
        for (int i = 0; i < 11; i++) begin
            send(16'd0);
            check($sformatf("gfall%0d_env", i), env_out, fall_env[i]);
            check($sformatf("gfall%0d_gate", i), gate_out, fall_gate[i]);
        end
        for (int i = 0; i < 200; i++) begin
            send(16'd0);
            if (env_out == 16'd5) break;
        end
        check("tail_start_env", env_out, 5);
        for (int i = 0; i < 5; i++) begin
            send(16'd0);
            check($sformatf("tail%0d_env", i), env_out, tail_env[i]);
            check($sformatf("tail%0d_phase", i), phase_out, tail_ph[i]);
        end
        send(16'd0);
        check("idle_stay_phase", phase_out, 0);
        check("idle_stay_env", env_out, 0);

        // 6: back-to-back strobes, then retrigger during hold.
        do_reset();
        @(negedge clk);
        sample_in = 16'd1000;
        in_ready  = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_e0_rdy", out_ready, 0);
        @(negedge clk);
        sample_in = 16'd30000;
        @(posedge clk);
        #1;
        check("b2b_a_rdy", out_ready, 1);
        check("b2b_a_env", env_out, 250);
        @(negedge clk);
        in_ready = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_b_rdy", out_ready, 1);
        check("b2b_b_env", env_out, 7687);
        @(posedge clk);
        #1;
        check("b2b_end_rdy", out_ready, 0);

        send(16'd0);
        repeat (200) send(16'd0);
        check("retrig_pre_phase", phase_out, 2);
        send(16'd10000);
        check("retrig_phase", phase_out, 1);
        check("retrig_env", env_out, 8265);
        send(16'd0);
        holds = 1;
        for (int i = 0; i < 1000; i++) begin
            send(16'd0);
            if (phase_out != 2'd2) break;
            holds++;
        end
        check("retrig_hold_len", holds, 480);
        check("retrig_fall_phase", phase_out, 3);
        check("retrig_fall_env", env_out, 8265);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
